control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired control sequencer for the 32-bit Mini SRC datapath; sits directly upstream of `datapath`.
- Drives every datapath control input (bus encoder selects, register enables, ALU select, memory strobes, Gra/Grb/Grc/Rin/Rout/BAout/conIn). The per-instruction fetch/execute step sequences previously driven by hand in benches now come from RTL.
- One control step per clock cycle.

Parameters:
- `ENC_W`, 32, width of `enc_out` and `reg_en` one-hot select vectors.
- `ALU_W`, 6, width of `ALU_Sel`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `clr_n`  in  1  asynchronous active-low reset.
- `ir`  in  32  IR register contents from datapath. Fields: opcode `ir[31:27]`, ra `ir[26:23]`, rb `ir[22:19]`, rc `ir[18:15]`.
- `con_ff`  in  1  branch condition flip-flop output.
- `stop`  in  1  halt request, sampled at end of each instruction.
- `enc_out`  out  32  bus encoder select: PC 20, MAR 23, Zlow 19, MDR 22, IR 21, Y 24, C(sign-ext const) 25.
- `reg_en`  out  32  register enables, same index map.
- `ALU_Sel`  out  6  ALU operation: ADD 0, SUB 1, AND 2, OR 3.
- `read`  out  1  memory read; also MDR mux select (1 = Mdatain, 0 = bus).
- `write`  out  1  memory write.
- `incPC`  out  1  ALU computes PC+1 into Z.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`  out  1 each  select-and-encode controls.
- `conIn`  out  1  load CON flip-flop.
- `run`  out  1  high while executing, low in HALT.
- `illegal_op`  out  1  see Optional Feature.

Behaviour:
- **Reset (`clr_n` = 0, any time):** state goes to RST immediately. All outputs are 0, including `run` and `ALU_Sel`. A reset mid-instruction abandons the instruction with no partial write.
- **RST → T0** on the first clock edge after `clr_n` rises.
- **Output timing:** all outputs are combinational decodes of the registered state plus latched opcode. Only the signals listed for a step are 1; everything else is 0 (`ALU_Sel` 0 unless stated).
- **Opcode latch:** captured from `ir` at the end of T2. It is used for T3–T7, so later `ir` changes do not affect the current instruction.
- **Fetch:**
  - T0: enc[20], en[23], incPC, en[19].
  - T1: enc[19], en[20], read, en[22].
  - T2: enc[22], en[21].
- **ld 00000:**
  - T3: Grb, BAout, en[24].
  - T4: enc[25], ALU ADD, en[19].
  - T5: enc[19], en[23].
  - T6: read, en[22].
  - T7: enc[22], Gra, Rin.
- **ldi 00001:** T3–T4 as ld; T5: enc[19], Gra, Rin.
- **st 00010:**
  - T3–T5 as ld.
  - T6: Gra, Rout, en[22] (`read` = 0).
  - T7: write.
- **add 00011 / sub 00100 / and 01001 / or 01010:**
  - T3: Grb, Rout, en[24].
  - T4: Grc, Rout, ALU op, en[19].
  - T5: enc[19], Gra, Rin.
- **addi 01011:** T3: Grb, Rout, en[24]; T4: enc[25], ADD, en[19]; T5: enc[19], Gra, Rin.
- **br 10010:**
  - T3: Gra, Rout, conIn.
  - T4: enc[20], en[24].
  - T5: enc[25], ADD, en[19].
  - T6: enc[19], en[20] only if `con_ff` = 1; otherwise all outputs 0.
- **jr 10011:** T3: Gra, Rout, en[20].
- **nop 11010:** ends after T2.
- **halt 11011:** T3 → HALT. HALT: `run` = 0, all other outputs 0, exits only via reset.
- **Instruction end:** the last listed step of each instruction goes to T0, or to HALT if `stop` = 1 on that edge.
- **Unknown opcode:** see Optional Feature.

Optional Feature:
- Macro: `CU_ILLEGAL_TRAP_EN`.
- Defined: unknown opcode at T3 → HALT. `illegal_op` = 1 while in HALT from a trap, cleared only by reset.
- Undefined: unknown opcode behaves as nop; `illegal_op` is tied 0.

Decomposition:
- Package `cu_pkg`:
  - opcode constants;
  - state encoding (RST, T0–T7, HALT, 4 bits);
  - bus/enable index constants (PC_IDX = 20, ...);
  - ALU code constants.
- Sub-module `cu_decode`: purely combinational; inputs state, opcode, `con_ff`; outputs the full control word and a `last_step` flag.
- Top level: state register, opcode latch, next-state logic.

Test Plan:
- **Reset mid-execute:** pulse `clr_n` = 0 during ld T5 → all outputs 0 asynchronously. First cycle after release is RST, then T0 with enc[20], en[23], incPC, en[19] = 1.
- **ld R1,0x55(R2):** `ir` = 0x00900055 → T3 Grb/BAout/en[24]; T4 enc[25]/en[19]/ALU_Sel = 0; T6 read/en[22]; T7 enc[22]/Gra/Rin; next cycle T0.
- **sub R3,R4,R5:** `ir` = 0x21A28000 → T4 Grc/Rout/ALU_Sel = 1/en[19]; T5 Gra/Rin; 6 cycles total.
- **st 0x20(R0),R6:** `ir` = 0x13000020 → T6 Gra/Rout/en[22] with read = 0; T7 write = 1 for exactly one cycle.
- **br:** with `con_ff` = 0, T6 has en[20] = 0; with `con_ff` = 1, T6 has enc[19]/en[20] = 1.
- **halt/stop/illegal:**
  - halt opcode (`ir` = 0xD8000000) → `run` falls at T3 edge and stays 0.
  - `stop` = 1 during ldi T5 → HALT.
  - Opcode 11111 → HALT with `illegal_op` = 1 when `CU_ILLEGAL_TRAP_EN` is defined, else back to T0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: states, opcodes,
// bus/enable index map and ALU operation codes.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int unsigned ZLO_IDX = 19;
  localparam int unsigned PC_IDX  = 20;
  localparam int unsigned IR_IDX  = 21;
  localparam int unsigned MDR_IDX = 22;
  localparam int unsigned MAR_IDX = 23;
  localparam int unsigned Y_IDX   = 24;
  localparam int unsigned C_IDX   = 25;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_AND = 2;
  localparam int unsigned ALU_OR  = 3;

  function automatic logic op_known(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_BR, OP_JR, OP_NOP, OP_HALT: op_known = 1'b1;
      default:                       op_known = 1'b0;
    endcase
  endfunction

  function automatic int unsigned alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      default: alu_code = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational control-word decode for one control step.
// Unknown opcodes end after T2 unless CU_ILLEGAL_TRAP_EN is defined.
module cu_decode
  import cu_pkg::*;
#(
  parameter int unsigned ENC_W = 32,
  parameter int unsigned ALU_W = 6
) (
  input  state_t             state,
  input  logic [4:0]         opcode,
  input  logic               con_ff,
  output logic [ENC_W-1:0]   enc_out,
  output logic [ENC_W-1:0]   reg_en,
  output logic [ALU_W-1:0]   alu_sel,
  output logic               read,
  output logic               write,
  output logic               inc_pc,
  output logic               gra,
  output logic               grb,
  output logic               grc,
  output logic               rin,
  output logic               rout,
  output logic               ba_out,
  output logic               con_in,
  output logic               last_step
);

  logic is_alu_rr;
  logic is_mem;

  assign is_alu_rr = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
  assign is_mem    = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);

  always_comb begin
    enc_out   = '0;
    reg_en    = '0;
    alu_sel   = '0;
    read      = 1'b0;
    write     = 1'b0;
    inc_pc    = 1'b0;
    gra       = 1'b0;
    grb       = 1'b0;
    grc       = 1'b0;
    rin       = 1'b0;
    rout      = 1'b0;
    ba_out    = 1'b0;
    con_in    = 1'b0;
    last_step = 1'b0;

    case (state)
      ST_T0: begin
        enc_out[PC_IDX]  = 1'b1;
        reg_en[MAR_IDX]  = 1'b1;
        reg_en[ZLO_IDX]  = 1'b1;
        inc_pc           = 1'b1;
      end
      ST_T1: begin
        enc_out[ZLO_IDX] = 1'b1;
        reg_en[PC_IDX]   = 1'b1;
        reg_en[MDR_IDX]  = 1'b1;
        read             = 1'b1;
      end
      ST_T2: begin
        enc_out[MDR_IDX] = 1'b1;
        reg_en[IR_IDX]   = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
        last_step        = (opcode == OP_NOP);
`else
        last_step        = (opcode == OP_NOP) || !op_known(opcode);
`endif
      end
      ST_T3: begin
        if (is_mem) begin
          grb            = 1'b1;
          ba_out         = 1'b1;
          reg_en[Y_IDX]  = 1'b1;
        end else if (is_alu_rr || opcode == OP_ADDI) begin
          grb            = 1'b1;
          rout           = 1'b1;
          reg_en[Y_IDX]  = 1'b1;
        end else if (opcode == OP_BR) begin
          gra            = 1'b1;
          rout           = 1'b1;
          con_in         = 1'b1;
        end else if (opcode == OP_JR) begin
          gra            = 1'b1;
          rout           = 1'b1;
          reg_en[PC_IDX] = 1'b1;
          last_step      = 1'b1;
        end
      end
      ST_T4: begin
        if (is_mem || opcode == OP_ADDI) begin
          enc_out[C_IDX]  = 1'b1;
          alu_sel         = ALU_W'(ALU_ADD);
          reg_en[ZLO_IDX] = 1'b1;
        end else if (is_alu_rr) begin
          grc             = 1'b1;
          rout            = 1'b1;
          alu_sel         = ALU_W'(alu_code(opcode));
          reg_en[ZLO_IDX] = 1'b1;
        end else if (opcode == OP_BR) begin
          enc_out[PC_IDX] = 1'b1;
          reg_en[Y_IDX]   = 1'b1;
        end
      end
      ST_T5: begin
        if (opcode == OP_LD || opcode == OP_ST) begin
          enc_out[ZLO_IDX] = 1'b1;
          reg_en[MAR_IDX]  = 1'b1;
        end else if (opcode == OP_LDI || is_alu_rr || opcode == OP_ADDI) begin
          enc_out[ZLO_IDX] = 1'b1;
          gra              = 1'b1;
          rin              = 1'b1;
          last_step        = 1'b1;
        end else if (opcode == OP_BR) begin
          enc_out[C_IDX]   = 1'b1;
          alu_sel          = ALU_W'(ALU_ADD);
          reg_en[ZLO_IDX]  = 1'b1;
        end
      end
      ST_T6: begin
        if (opcode == OP_LD) begin
          read             = 1'b1;
          reg_en[MDR_IDX]  = 1'b1;
        end else if (opcode == OP_ST) begin
          gra              = 1'b1;
          rout             = 1'b1;
          reg_en[MDR_IDX]  = 1'b1;
        end else if (opcode == OP_BR) begin
          enc_out[ZLO_IDX] = con_ff;
          reg_en[PC_IDX]   = con_ff;
          last_step        = 1'b1;
        end
      end
      ST_T7: begin
        if (opcode == OP_LD) begin
          enc_out[MDR_IDX] = 1'b1;
          gra              = 1'b1;
          rin              = 1'b1;
          last_step        = 1'b1;
        end else if (opcode == OP_ST) begin
          write            = 1'b1;
          last_step        = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: state register, opcode latch, next state.
// Optional illegal-opcode trap enabled by defining CU_ILLEGAL_TRAP_EN.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned ENC_W = 32,
  parameter int unsigned ALU_W = 6
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             stop,
  output logic [ENC_W-1:0] enc_out,
  output logic [ENC_W-1:0] reg_en,
  output logic [ALU_W-1:0] ALU_Sel,
  output logic             read,
  output logic             write,
  output logic             incPC,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             conIn,
  output logic             run,
  output logic             illegal_op
);

  state_t     state_q, state_d;
  logic [4:0] op_q;
  logic [4:0] op_eff;
  logic       last_step;
  logic       trap_hit;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^ir[26:0];

  // T2 decides nop/unknown termination before the latch has captured the new opcode
  assign op_eff = (state_q == ST_T2) ? ir[31:27] : op_q;

`ifdef CU_ILLEGAL_TRAP_EN
  assign trap_hit = (state_q == ST_T3) && !op_known(op_q);
`else
  assign trap_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T2)
        op_q <= ir[31:27];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: begin
        if (last_step)
          state_d = stop ? ST_HALT : ST_T0;
        else if ((state_q == ST_T3 && op_q == OP_HALT) || trap_hit)
          state_d = ST_HALT;
        else
          state_d = state_t'(state_q + 4'd1);
      end
    endcase
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n)
      illegal_q <= 1'b0;
    else if (trap_hit)
      illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q && (state_q == ST_HALT);
`else
  assign illegal_op = 1'b0;
`endif

  assign run = (state_q != ST_RST) && (state_q != ST_HALT);

  cu_decode #(
    .ENC_W(ENC_W),
    .ALU_W(ALU_W)
  ) u_decode (
    .state     (state_q),
    .opcode    (op_eff),
    .con_ff    (con_ff),
    .enc_out   (enc_out),
    .reg_en    (reg_en),
    .alu_sel   (ALU_Sel),
    .read      (read),
    .write     (write),
    .inc_pc    (incPC),
    .gra       (Gra),
    .grb       (Grb),
    .grc       (Grc),
    .rin       (Rin),
    .rout      (Rout),
    .ba_out    (BAout),
    .con_in    (conIn),
    .last_step (last_step)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: compares the full control word every step
// against hand-written expectations.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clr_n = 1'b1;
  logic [31:0] ir = '0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] enc_out, reg_en;
  logic [5:0]  ALU_Sel;
  logic        read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn, run, illegal_op;

  int checks = 0;
  int failures = 0;

  localparam logic [11:0] F_READ  = 12'h800;
  localparam logic [11:0] F_WRITE = 12'h400;
  localparam logic [11:0] F_INC   = 12'h200;
  localparam logic [11:0] F_GRA   = 12'h100;
  localparam logic [11:0] F_GRB   = 12'h080;
  localparam logic [11:0] F_GRC   = 12'h040;
  localparam logic [11:0] F_RIN   = 12'h020;
  localparam logic [11:0] F_ROUT  = 12'h010;
  localparam logic [11:0] F_BA    = 12'h008;
  localparam logic [11:0] F_CON   = 12'h004;
  localparam logic [11:0] F_RUN   = 12'h002;
  localparam logic [11:0] F_ILL   = 12'h001;

  control_unit #(.ENC_W(32), .ALU_W(6)) dut (
    .clock(clock), .clr_n(clr_n), .ir(ir), .con_ff(con_ff), .stop(stop),
    .enc_out(enc_out), .reg_en(reg_en), .ALU_Sel(ALU_Sel),
    .read(read), .write(write), .incPC(incPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .conIn(conIn), .run(run), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  logic [81:0] obs;
  assign obs = {enc_out, reg_en, ALU_Sel, read, write, incPC, Gra, Grb, Grc,
                Rin, Rout, BAout, conIn, run, illegal_op};

  // Expected control word: one enc bit, up to two enable bits (-1 = none).
  function automatic logic [81:0] cw(input int enc_i, input int en_a, input int en_b,
                                     input logic [5:0] alu, input logic [11:0] f);
    logic [31:0] e, r;
    e = '0;
    r = '0;
    if (enc_i >= 0) e[enc_i] = 1'b1;
    if (en_a >= 0)  r[en_a]  = 1'b1;
    if (en_b >= 0)  r[en_b]  = 1'b1;
    return {e, r, alu, f};
  endfunction

  task automatic check_eq(input string tag, input logic [81:0] got, input logic [81:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    clr_n = 1'b0;
    #1;
    check_eq({tag, ".async"}, obs, '0);
    @(negedge clock);
    clr_n = 1'b1;
    #1;
    check_eq({tag, ".rst"}, obs, '0);
    tick;
  endtask

  // Entered at T0; leaves the state at T3 (or T0 for nop-like opcodes).
  task automatic fetch(input logic [31:0] instr, input string tag);
    ir = instr;
    check_eq({tag, ".t0"}, obs, cw(20, 23, 19, 6'd0, F_INC | F_RUN));
    tick;
    check_eq({tag, ".t1"}, obs, cw(19, 20, 22, 6'd0, F_READ | F_RUN));
    tick;
    check_eq({tag, ".t2"}, obs, cw(22, 21, -1, 6'd0, F_RUN));
    tick;
  endtask

  task automatic ea_steps(input string tag);
    check_eq({tag, ".t3"}, obs, cw(-1, 24, -1, 6'd0, F_GRB | F_BA | F_RUN));
    tick;
    check_eq({tag, ".t4"}, obs, cw(25, 19, -1, 6'd0, F_RUN));
    tick;
  endtask

  logic [31:0] rr_ir  [3] = '{32'h18000000, 32'h48000000, 32'h50000000};
  logic [5:0]  rr_alu [3] = '{6'd0, 6'd2, 6'd3};

  initial begin
    #2;
    do_reset("init");

    fetch(32'h00900055, "ld");
    ea_steps("ld");
    check_eq("ld.t5", obs, cw(19, 23, -1, 6'd0, F_RUN));
    tick;
    check_eq("ld.t6", obs, cw(-1, 22, -1, 6'd0, F_READ | F_RUN));
    tick;
    check_eq("ld.t7", obs, cw(22, -1, -1, 6'd0, F_GRA | F_RIN | F_RUN));
    tick;

    fetch(32'h21A28000, "sub");
    ir = 32'h08000000;
    check_eq("sub.t3", obs, cw(-1, 24, -1, 6'd0, F_GRB | F_ROUT | F_RUN));
    tick;
    check_eq("sub.t4", obs, cw(-1, 19, -1, 6'd1, F_GRC | F_ROUT | F_RUN));
    tick;
    check_eq("sub.t5", obs, cw(19, -1, -1, 6'd0, F_GRA | F_RIN | F_RUN));
    tick;

    for (int i = 0; i < 3; i++) begin
      fetch(rr_ir[i], "rr");
      check_eq("rr.t3", obs, cw(-1, 24, -1, 6'd0, F_GRB | F_ROUT | F_RUN));
      tick;
      check_eq("rr.t4", obs, cw(-1, 19, -1, rr_alu[i], F_GRC | F_ROUT | F_RUN));
      tick;
      check_eq("rr.t5", obs, cw(19, -1, -1, 6'd0, F_GRA | F_RIN | F_RUN));
      tick;
    end

    fetch(32'h58000000, "addi");
    check_eq("addi.t3", obs, cw(-1, 24, -1, 6'd0, F_GRB | F_ROUT | F_RUN));
    tick;
    check_eq("addi.t4", obs, cw(25, 19, -1, 6'd0, F_RUN));
    tick;
    check_eq("addi.t5", obs, cw(19, -1, -1, 6'd0, F_GRA | F_RIN | F_RUN));
    tick;

    fetch(32'h13000020, "st");
    ea_steps("st");
    check_eq("st.t5", obs, cw(19, 23, -1, 6'd0, F_RUN));
    tick;
    check_eq("st.t6", obs, cw(-1, 22, -1, 6'd0, F_GRA | F_ROUT | F_RUN));
    tick;
    check_eq("st.t7", obs, cw(-1, -1, -1, 6'd0, F_WRITE | F_RUN));
    tick;

    for (int c = 0; c < 2; c++) begin
      con_ff = (c == 1);
      fetch(32'h90800000, "br");
      check_eq("br.t3", obs, cw(-1, -1, -1, 6'd0, F_GRA | F_ROUT | F_CON | F_RUN));
      tick;
      check_eq("br.t4", obs, cw(20, 24, -1, 6'd0, F_RUN));
      tick;
      check_eq("br.t5", obs, cw(25, 19, -1, 6'd0, F_RUN));
      tick;
      if (c == 1) check_eq("br.t6_taken", obs, cw(19, 20, -1, 6'd0, F_RUN));
      else        check_eq("br.t6_not", obs, cw(-1, -1, -1, 6'd0, F_RUN));
      tick;
    end
    con_ff = 1'b0;

    fetch(32'h98000000, "jr");
    check_eq("jr.t3", obs, cw(-1, 20, -1, 6'd0, F_GRA | F_ROUT | F_RUN));
    tick;

    fetch(32'hD0000000, "nop");

    fetch(32'hF8000000, "unk");
`ifdef CU_ILLEGAL_TRAP_EN
    check_eq("unk.t3", obs, cw(-1, -1, -1, 6'd0, F_RUN));
    tick;
    check_eq("unk.halt", obs, cw(-1, -1, -1, 6'd0, F_ILL));
    tick;
    check_eq("unk.halt2", obs, cw(-1, -1, -1, 6'd0, F_ILL));
    do_reset("unk");
`endif

    fetch(32'h08800000, "ldi");
    stop = 1'b1;
    ea_steps("ldi");
    check_eq("ldi.t5", obs, cw(19, -1, -1, 6'd0, F_GRA | F_RIN | F_RUN));
    tick;
    check_eq("ldi.stop_halt", obs, '0);
    tick;
    check_eq("ldi.stop_halt2", obs, '0);
    stop = 1'b0;
    do_reset("stop");

    fetch(32'h00900055, "ld2");
    ea_steps("ld2");
    check_eq("ld2.t5", obs, cw(19, 23, -1, 6'd0, F_RUN));
    do_reset("mid");

    fetch(32'hD8000000, "halt");
    check_eq("halt.t3", obs, cw(-1, -1, -1, 6'd0, F_RUN));
    tick;
    check_eq("halt.h1", obs, '0);
    tick;
    check_eq("halt.h2", obs, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
